// File: rtl/com_smoother_if.sv
// com_smoother_if: centroid-in / smoothed-position-out bundle for com_smoother.
//   x_in, y_in        raw centroid from center_of_mass (11 / 10 bits)
//   valid_in          one-cycle pulse, x_in/y_in valid
//   frame_end_in      one-cycle pulse closing each frame window
//   x_out, y_out      smoothed position (11 / 10 bits)
//   valid_out         one-cycle pulse when x_out/y_out update
//   locked_out        level, high while tracking or coasting
// master drives the centroid side, slave is the smoother itself.
interface com_smoother_if;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic        valid_in;
  logic        frame_end_in;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        valid_out;
  logic        locked_out;

  modport master (
    output x_in, y_in, valid_in, frame_end_in,
    input  x_out, y_out, valid_out, locked_out
  );

  modport slave (
    input  x_in, y_in, valid_in, frame_end_in,
    output x_out, y_out, valid_out, locked_out
  );
endinterface

// File: rtl/com_smoother.sv
// com_smoother: exponential-moving-average smoother for the per-frame centroid.
// Rejects single-frame outlier jumps, snaps after repeated rejections, coasts
// through short dropouts and reports lock status.
// Ports:
//   clk_in   system clock
//   rst_in   synchronous active-high reset
//   bus      com_smoother_if.slave (centroid in, smoothed position/lock out)
// Sample path: valid_in registered (p0), update computed from p0, outputs
// registered (p1) -> valid_out two cycles after valid_in.
module com_smoother #(
  parameter int ALPHA_SHIFT = 2,
  parameter int MAX_JUMP    = 200,
  parameter int REACQ_COUNT = 3,
  parameter int LOST_FRAMES = 8
) (
  input logic          clk_in,
  input logic          rst_in,
  com_smoother_if.slave bus
);

  localparam int XW  = 11;
  localparam int YW  = 10;
  localparam int DW  = XW + 1;
  localparam int AXW = XW + ALPHA_SHIFT;
  localparam int AYW = YW + ALPHA_SHIFT;
  localparam int MW  = $clog2(LOST_FRAMES + 1);
  localparam int RW  = $clog2(REACQ_COUNT + 1);

  typedef enum logic [1:0] {IDLE, TRACK, COAST} state_t;

  // acc + ((sample<<A) - acc) >>> A, arithmetic shift floors negative steps.
  // y shares this by zero-extension; its result stays within its own range.
  function automatic logic [AXW-1:0] ema_step(input logic [AXW-1:0] acc,
                                              input logic [XW-1:0]  sample);
    logic [AXW-1:0]      target;
    logic signed [AXW:0] diff;
    logic signed [AXW:0] sum;
    target = AXW'(sample) << ALPHA_SHIFT;
    diff   = $signed({1'b0, target}) - $signed({1'b0, acc});
    sum    = $signed({1'b0, acc}) + (diff >>> ALPHA_SHIFT);
    return AXW'(sum);
  endfunction

  function automatic logic [DW-1:0] abs_diff(input logic [XW-1:0] a,
                                             input logic [XW-1:0] b);
    logic signed [DW-1:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? -d : d;
  endfunction

  state_t          state_q, state_d;
  logic            vld_p0_q, vld_p0_d;
  logic [XW-1:0]   x_p0_q, x_p0_d;
  logic [YW-1:0]   y_p0_q, y_p0_d;
  logic            vld_p1_q, vld_p1_d;
  logic [AXW-1:0]  acc_x_q, acc_x_d;
  logic [AYW-1:0]  acc_y_q, acc_y_d;
  logic [XW-1:0]   x_out_q, x_out_d;
  logic [YW-1:0]   y_out_q, y_out_d;
  logic [MW-1:0]   miss_cnt_q, miss_cnt_d;
  logic [RW-1:0]   rej_cnt_q, rej_cnt_d;
  logic            seen_q, seen_d;

  logic            do_snap, do_ema, outlier, miss;
  logic [DW-1:0]   abs_dx, abs_dy;

  always_comb begin
    state_d    = state_q;
    acc_x_d    = acc_x_q;
    acc_y_d    = acc_y_q;
    x_out_d    = x_out_q;
    y_out_d    = y_out_q;
    miss_cnt_d = miss_cnt_q;
    rej_cnt_d  = rej_cnt_q;
    vld_p1_d   = 1'b0;
    do_snap    = 1'b0;
    do_ema     = 1'b0;

    // stage p0: capture the raw sample
    vld_p0_d = bus.valid_in;
    x_p0_d   = bus.x_in;
    y_p0_d   = bus.y_in;

    // stage p1: classify the registered sample against the current output
    abs_dx  = abs_diff(x_p0_q, x_out_q);
    abs_dy  = abs_diff(XW'(y_p0_q), XW'(y_out_q));
    outlier = (abs_dx > DW'(MAX_JUMP)) || (abs_dy > DW'(MAX_JUMP));

    if (vld_p0_q) begin
      if (state_q == IDLE) begin
        do_snap    = 1'b1;
        state_d    = TRACK;
        rej_cnt_d  = '0;
        miss_cnt_d = '0;
      end else begin
        if (outlier) begin
          // The REACQ_COUNT-th consecutive rejection means the target really moved.
          if (rej_cnt_q == RW'(REACQ_COUNT - 1)) begin
            do_snap   = 1'b1;
            rej_cnt_d = '0;
          end else begin
            rej_cnt_d = rej_cnt_q + 1'b1;
          end
        end else begin
          do_ema    = 1'b1;
          rej_cnt_d = '0;
        end
        if (state_q == COAST) begin
          state_d    = TRACK;
          miss_cnt_d = '0;
        end
      end
    end

    if (do_snap) begin
      acc_x_d = AXW'(x_p0_q) << ALPHA_SHIFT;
      acc_y_d = AYW'(y_p0_q) << ALPHA_SHIFT;
    end else if (do_ema) begin
      acc_x_d = ema_step(acc_x_q, x_p0_q);
      acc_y_d = AYW'(ema_step(AXW'(acc_y_q), XW'(y_p0_q)));
    end
    if (do_snap || do_ema) begin
      x_out_d  = acc_x_d[AXW-1:ALPHA_SHIFT];
      y_out_d  = acc_y_d[AYW-1:ALPHA_SHIFT];
      vld_p1_d = 1'b1;
    end

    // Frame windows are judged on the live strobes so lock drops the cycle
    // after the closing frame_end; a coincident valid_in belongs to the window.
    miss   = bus.frame_end_in && !seen_q && !bus.valid_in;
    seen_d = bus.frame_end_in ? 1'b0 : (seen_q || bus.valid_in);

    if (miss) begin
      unique case (state_d)
        TRACK: begin
          miss_cnt_d = MW'(1);
          state_d    = COAST;
        end
        COAST: begin
          miss_cnt_d = miss_cnt_d + 1'b1;
          if (miss_cnt_d == MW'(LOST_FRAMES)) begin
            state_d   = IDLE;
            rej_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      vld_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      x_out_q    <= '0;
      y_out_q    <= '0;
      miss_cnt_q <= '0;
      rej_cnt_q  <= '0;
      seen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vld_p0_q   <= vld_p0_d;
      vld_p1_q   <= vld_p1_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      x_out_q    <= x_out_d;
      y_out_q    <= y_out_d;
      miss_cnt_q <= miss_cnt_d;
      rej_cnt_q  <= rej_cnt_d;
      seen_q     <= seen_d;
    end
  end

  always_ff @(posedge clk_in) begin
    x_p0_q <= x_p0_d;
    y_p0_q <= y_p0_d;
  end

  assign bus.x_out      = x_out_q;
  assign bus.y_out      = y_out_q;
  assign bus.valid_out  = vld_p1_q;
  assign bus.locked_out = (state_q != IDLE);

endmodule

// File: tb/tb_com_smoother.sv
// Scoreboard bench for com_smoother: each issued sample that should produce an
// update pushes (x, y, cycle) into a queue; the monitor pops on valid_out.
module tb_com_smoother;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  com_smoother_if bus();

  com_smoother #(
    .ALPHA_SHIFT(2), .MAX_JUMP(200), .REACQ_COUNT(3), .LOST_FRAMES(8)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  typedef struct { int x; int y; int c; } exp_t;
  exp_t q[$];

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every valid_out must match the oldest pending expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.valid_out === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid_out: got x=%0d y=%0d, want no update (cycle %0d)",
                 bus.x_out, bus.y_out, cyc);
      end else begin
        e = q.pop_front();
        check("out_x", int'(bus.x_out), e.x);
        check("out_y", int'(bus.y_out), e.y);
        check("out_latency_cycle", cyc, e.c);
        check("out_locked", int'(bus.locked_out), 1);
      end
    end
  end

  // Called at a negedge; holds valid_in for one cycle and returns at the next negedge.
  task automatic send(input int x, input int y, input bit fe,
                      input bit exp_out, input int ex, input int ey);
    exp_t e;
    bus.x_in         = 11'(x);
    bus.y_in         = 10'(y);
    bus.valid_in     = 1'b1;
    bus.frame_end_in = fe;
    if (exp_out) begin
      e.x = ex; e.y = ey; e.c = cyc + 2;
      q.push_back(e);
    end
    @(negedge clk);
    bus.valid_in     = 1'b0;
    bus.frame_end_in = 1'b0;
  endtask

  task automatic fe_pulse();
    bus.frame_end_in = 1'b1;
    @(negedge clk);
    bus.frame_end_in = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    bus.x_in         = '0;
    bus.y_in         = '0;
    bus.valid_in     = 1'b0;
    bus.frame_end_in = 1'b0;
    tick(3);
    check("reset_x", int'(bus.x_out), 0);
    check("reset_y", int'(bus.y_out), 0);
    check("reset_valid", int'(bus.valid_out), 0);
    check("reset_locked", int'(bus.locked_out), 0);
    rst = 1'b0;
    tick(1);

    // Snap, EMA up, EMA down with floor, then three outliers forcing a snap.
    send(100, 50, 0, 1, 100, 50);
    send(200, 90, 0, 1, 125, 60);
    send(100, 60, 0, 1, 118, 60);
    send(600, 60, 0, 0, 0, 0);
    send(600, 60, 0, 0, 0, 0);
    send(600, 60, 0, 1, 600, 60);
    tick(4);
    check("reacq_hold_x", int'(bus.x_out), 600);
    check("reacq_locked", int'(bus.locked_out), 1);

    // Lock at 125,60; the first frame_end closes the window holding the sample,
    // the next eight are misses.
    do_reset();
    send(100, 50, 0, 1, 100, 50);
    send(200, 90, 0, 1, 125, 60);
    tick(3);
    fe_pulse();
    check("window_close_locked", int'(bus.locked_out), 1);
    for (int i = 1; i <= 8; i++) begin
      tick(2);
      fe_pulse();
      check($sformatf("miss%0d_locked", i), int'(bus.locked_out), (i < 8) ? 1 : 0);
    end
    tick(2);
    check("lost_hold_x", int'(bus.x_out), 125);
    check("lost_hold_y", int'(bus.y_out), 60);
    check("lost_locked", int'(bus.locked_out), 0);
    send(10, 10, 0, 1, 10, 10);
    tick(3);
    check("relock_locked", int'(bus.locked_out), 1);

    // Sample coincident with frame_end, then a sampled window: no misses.
    fe_pulse();
    tick(2);
    send(10, 10, 1, 1, 10, 10);
    tick(2);
    send(10, 10, 0, 1, 10, 10);
    tick(2);
    fe_pulse();
    tick(2);
    check("coincident_locked", int'(bus.locked_out), 1);

    // Jump boundaries: 200 accepted, 201 rejected; an accept clears rej_cnt.
    send(210, 10, 0, 1, 60, 10);
    send(261, 10, 0, 0, 0, 0);
    send(60, 10, 0, 1, 60, 10);
    send(261, 10, 0, 0, 0, 0);
    send(261, 10, 0, 0, 0, 0);
    send(60, 10, 0, 1, 60, 10);
    send(60, 211, 0, 0, 0, 0);
    send(60, 210, 0, 1, 60, 60);
    tick(4);
    check("boundary_hold_y", int'(bus.y_out), 60);

    // In-flight sample discarded by reset in the following cycle.
    do_reset();
    tick(1);
    send(300, 200, 0, 0, 0, 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(5);
    check("flush_x", int'(bus.x_out), 0);
    check("flush_y", int'(bus.y_out), 0);
    check("flush_locked", int'(bus.locked_out), 0);

    check("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
